// File: rtl/parking_pkg.sv
// parking_pkg : shared constants, grant indices and helpers for the parking meter time path
// rev 1.0
`default_nettype none

package parking_pkg;

  localparam int CNT_W     = 14;
  localparam int SUM_W     = CNT_W + 1;
  localparam int GNT_W     = 7;
  localparam int ADD_SRCS  = 4;
  localparam int PEND_W    = 2;

  localparam int MAX_COUNT = 9999;
  localparam int ADD_VAL0  = 60;
  localparam int ADD_VAL1  = 120;
  localparam int ADD_VAL2  = 180;
  localparam int ADD_VAL3  = 300;
  localparam int RST1_VAL  = 15;
  localparam int RST2_VAL  = 150;
  localparam int PEND_MAX  = 3;

  localparam int GNT_ADD0  = 0;
  localparam int GNT_ADD1  = 1;
  localparam int GNT_ADD2  = 2;
  localparam int GNT_ADD3  = 3;
  localparam int GNT_RST1  = 4;
  localparam int GNT_RST2  = 5;
  localparam int GNT_TICK  = 6;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_RST2 = 3'd1,
    SEL_RST1 = 3'd2,
    SEL_ADD  = 3'd3,
    SEL_TICK = 3'd4
  } sel_e;

  // One extra bit of headroom so the carry is visible before clamping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b,
                                               input int               max_val);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > SUM_W'(max_val)) return CNT_W'(max_val);
    return sum[CNT_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/meter_update_arbiter_if.sv
// meter_update_arbiter_if : request strobes in, time count and status out
// rev 1.0
`default_nettype none

interface meter_update_arbiter_if;
  import parking_pkg::*;

  logic [ADD_SRCS-1:0] add_req;
  logic                rst1_req;
  logic                rst2_req;
  logic                tick;
  logic [CNT_W-1:0]    count;
  logic [GNT_W-1:0]    grant;
  logic                expired;
  logic                ovf;
  logic                busy;

  modport master (
    output add_req, rst1_req, rst2_req, tick,
    input  count, grant, expired, ovf, busy
  );

  modport slave (
    input  add_req, rst1_req, rst2_req, tick,
    output count, grant, expired, ovf, busy
  );

endinterface

`default_nettype wire

// File: rtl/meter_update_arbiter_rr.sv
// rr_arbiter4 : 4-way round-robin picker; pointer moves past the winner only when advance is high
// rev 1.0
`default_nettype none

module rr_arbiter4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       advance,
  output logic [3:0] gnt
);

  logic [1:0] ptr;
  logic [1:0] idx;
  logic [1:0] gnt_idx;
  logic       found;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= gnt_idx + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/meter_update_arbiter.sv
// meter_update_arbiter : captures add/preset/tick strobes and applies one granted update per clock
// rev 1.0
`default_nettype none

module meter_update_arbiter #(
  parameter int MAX_COUNT = parking_pkg::MAX_COUNT,
  parameter int ADD_VAL0  = parking_pkg::ADD_VAL0,
  parameter int ADD_VAL1  = parking_pkg::ADD_VAL1,
  parameter int ADD_VAL2  = parking_pkg::ADD_VAL2,
  parameter int ADD_VAL3  = parking_pkg::ADD_VAL3,
  parameter int RST1_VAL  = parking_pkg::RST1_VAL,
  parameter int RST2_VAL  = parking_pkg::RST2_VAL,
  parameter int PEND_MAX  = parking_pkg::PEND_MAX
) (
  input  logic                   clk,
  input  logic                   rst,
  meter_update_arbiter_if.slave  bus
);
  import parking_pkg::*;

  logic [GNT_W-1:0]    strobe;
  logic [GNT_W-1:0]    granted;
  logic [GNT_W-1:0]    pend_nz;
  logic [GNT_W-1:0]    drop;
  logic [ADD_SRCS-1:0] rr_gnt;
  logic                rr_advance;
  sel_e                sel;

  logic [CNT_W-1:0]    add_amt;
  logic [CNT_W-1:0]    count_next;
  logic                expired_next;

  logic [CNT_W-1:0]    count_reg;
  logic [GNT_W-1:0]    grant_reg;
  logic                expired_reg;
  logic                ovf_reg;

  assign strobe = {bus.tick, bus.rst2_req, bus.rst1_req, bus.add_req};

  // Strobe and grant on the same source cancel out; a strobe is lost only when it cannot be stored.
  for (genvar i = 0; i < GNT_W; i++) begin : g_src
    if (i == GNT_RST1 || i == GNT_RST2) begin : g_flag
      logic flag;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          flag <= 1'b0;
        end else if (strobe[i] != granted[i]) begin
          flag <= strobe[i];
        end
      end
      assign drop[i]    = strobe[i] & ~granted[i] & flag;
      assign pend_nz[i] = flag;
    end else begin : g_cnt
      logic [PEND_W-1:0] cnt;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt <= '0;
        end else if (strobe[i] && !granted[i] && cnt != PEND_W'(PEND_MAX)) begin
          cnt <= cnt + 1'b1;
        end else if (granted[i] && !strobe[i]) begin
          cnt <= cnt - 1'b1;
        end
      end
      assign drop[i]    = strobe[i] & ~granted[i] & (cnt == PEND_W'(PEND_MAX));
      assign pend_nz[i] = |cnt;
    end
  end

  always_comb begin
    sel = SEL_NONE;
    if (pend_nz[GNT_RST2])               sel = SEL_RST2;
    else if (pend_nz[GNT_RST1])          sel = SEL_RST1;
    else if (|pend_nz[ADD_SRCS-1:0])     sel = SEL_ADD;
    else if (pend_nz[GNT_TICK])          sel = SEL_TICK;
  end

  assign rr_advance = (sel == SEL_ADD);

  rr_arbiter4 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (pend_nz[ADD_SRCS-1:0]),
    .advance (rr_advance),
    .gnt     (rr_gnt)
  );

  assign add_amt = ({CNT_W{rr_gnt[GNT_ADD0]}} & CNT_W'(ADD_VAL0))
                 | ({CNT_W{rr_gnt[GNT_ADD1]}} & CNT_W'(ADD_VAL1))
                 | ({CNT_W{rr_gnt[GNT_ADD2]}} & CNT_W'(ADD_VAL2))
                 | ({CNT_W{rr_gnt[GNT_ADD3]}} & CNT_W'(ADD_VAL3));

  always_comb begin
    granted      = '0;
    count_next   = count_reg;
    expired_next = 1'b0;
    case (sel)
      SEL_RST2: begin
        granted[GNT_RST2] = 1'b1;
        count_next        = CNT_W'(RST2_VAL);
      end
      SEL_RST1: begin
        granted[GNT_RST1] = 1'b1;
        count_next        = CNT_W'(RST1_VAL);
      end
      SEL_ADD: begin
        granted[ADD_SRCS-1:0] = rr_gnt;
        count_next            = sat_add(count_reg, add_amt, MAX_COUNT);
      end
      SEL_TICK: begin
        // A tick at zero is still consumed so it cannot linger as a stale decrement.
        granted[GNT_TICK] = 1'b1;
        if (count_reg != '0) count_next = count_reg - 1'b1;
        expired_next      = (count_reg == CNT_W'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg   <= '0;
      grant_reg   <= '0;
      expired_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      count_reg   <= count_next;
      grant_reg   <= granted;
      expired_reg <= expired_next;
      ovf_reg     <= ovf_reg | (|drop);
    end
  end

  assign bus.count   = count_reg;
  assign bus.grant   = grant_reg;
  assign bus.expired = expired_reg;
  assign bus.ovf     = ovf_reg;
  assign bus.busy    = |pend_nz;

endmodule

`default_nettype wire

// File: tb/tb_meter_update_arbiter.sv
// tb_meter_update_arbiter : directed scenarios plus random strobes against a queue-count reference model
// rev 1.0
`default_nettype none

module tb_meter_update_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  meter_update_arbiter_if bus();

  meter_update_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference state: outstanding requests per source (0-3 add, 4 rst1, 5 rst2, 6 tick).
  int m_pend[7];
  int m_ptr, m_count, m_grant, m_exp, m_ovf;
  int add_val[4] = '{60, 120, 180, 300};

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_ptr = 0; m_count = 0; m_grant = 0; m_exp = 0; m_ovf = 0;
  endfunction

  function automatic int model_busy();
    int b = 0;
    foreach (m_pend[i]) if (m_pend[i] > 0) b = 1;
    return b;
  endfunction

  function automatic void model_step(input logic [3:0] a, input logic r1, input logic r2, input logic tk);
    int g = -1;
    int lim;
    logic [6:0] s;
    s = {tk, r2, r1, a};
    if (m_pend[5] > 0) g = 5;
    else if (m_pend[4] > 0) g = 4;
    else begin
      for (int k = 0; k < 4; k++)
        if (g < 0 && m_pend[(m_ptr + k) % 4] > 0) g = (m_ptr + k) % 4;
      if (g < 0 && m_pend[6] > 0) g = 6;
    end
    m_exp = 0;
    if (g >= 0 && g < 4) begin
      m_count = (m_count + add_val[g] > 9999) ? 9999 : m_count + add_val[g];
      m_ptr   = (g + 1) % 4;
    end else if (g == 4) m_count = 15;
    else if (g == 5) m_count = 150;
    else if (g == 6 && m_count > 0) begin
      m_exp   = (m_count == 1) ? 1 : 0;
      m_count = m_count - 1;
    end
    for (int i = 0; i < 7; i++) begin
      lim = (i == 4 || i == 5) ? 1 : 3;
      if (s[i] && g != i) begin
        if (m_pend[i] == lim) m_ovf = 1;
        else m_pend[i] = m_pend[i] + 1;
      end else if (!s[i] && g == i) begin
        m_pend[i] = m_pend[i] - 1;
      end
    end
    m_grant = (g >= 0) ? (1 << g) : 0;
  endfunction

  task automatic apply(input logic [3:0] a, input logic r1, input logic r2, input logic tk);
    bus.add_req = a; bus.rst1_req = r1; bus.rst2_req = r2; bus.tick = tk;
    @(posedge clk);
    if (rst) model_step(a, r1, r2, tk);
    #1;
    bus.add_req = '0; bus.rst1_req = 1'b0; bus.rst2_req = 1'b0; bus.tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply(4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    apply(4'hF, 1'b1, 1'b1, 1'b1);
    apply(4'hF, 1'b1, 1'b1, 1'b1);
    vecs++; if (bus.count !== 14'd0) begin errs++; $display("FAIL reset count: got %0d want 0", bus.count); end
    vecs++; if (bus.grant !== 7'd0) begin errs++; $display("FAIL reset grant: got %b want 0", bus.grant); end
    vecs++; if (bus.expired !== 1'b0) begin errs++; $display("FAIL reset expired: got %b want 0", bus.expired); end
    vecs++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL reset ovf: got %b want 0", bus.ovf); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    model_reset();
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_tick_at_zero();
    repeat (3) begin
      apply(4'h0, 1'b0, 1'b0, 1'b1);
      vecs++; if (bus.grant !== 7'd0) begin errs++; $display("FAIL tick0 latency grant: got %b want 0", bus.grant); end
      idle(1);
      vecs++; if (bus.grant !== 7'h40 || bus.grant !== 7'(m_grant)) begin errs++; $display("FAIL tick0 grant: got %b want 1000000", bus.grant); end
      vecs++; if (bus.count !== 14'd0) begin errs++; $display("FAIL tick0 count: got %0d want 0", bus.count); end
      vecs++; if (bus.expired !== 1'b0) begin errs++; $display("FAIL tick0 expired: got %b want 0", bus.expired); end
    end
    vecs++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL tick0 ovf: got %b want 0", bus.ovf); end
  endtask

  task automatic test_add_single();
    apply(4'b0001, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.grant !== 7'd0) begin errs++; $display("FAIL add0 latency grant: got %b want 0", bus.grant); end
    idle(1);
    vecs++; if (bus.grant !== 7'h01) begin errs++; $display("FAIL add0 grant: got %b want 0000001", bus.grant); end
    vecs++; if (bus.count !== 14'd60 || m_count != 60) begin errs++; $display("FAIL add0 count: got %0d want 60", bus.count); end
    repeat (3) apply(4'h0, 1'b0, 1'b0, 1'b1);
    idle(3);
    vecs++; if (bus.count !== 14'd57 || m_count != 57) begin errs++; $display("FAIL add0 ticks count: got %0d want 57", bus.count); end
  endtask

  task automatic test_add_all_saturate();
    logic [6:0] seq [6];
    seq = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h40, 7'h00};
    repeat (34) apply(4'b1000, 1'b0, 1'b0, 1'b0);
    idle(2);
    vecs++; if (bus.count !== 14'd9999) begin errs++; $display("FAIL sat ceiling count: got %0d want 9999", bus.count); end
    repeat (199) apply(4'h0, 1'b0, 1'b0, 1'b1);
    idle(2);
    vecs++; if (bus.count !== 14'd9800) begin errs++; $display("FAIL sat preload count: got %0d want 9800", bus.count); end
    apply(4'hF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      vecs++; if (bus.grant !== seq[i] || bus.grant !== 7'(m_grant)) begin errs++; $display("FAIL sat order step %0d grant: got %b want %b", i, bus.grant, seq[i]); end
      vecs++; if (bus.count !== 14'(m_count)) begin errs++; $display("FAIL sat order step %0d count: got %0d want %0d", i, bus.count, m_count); end
    end
    vecs++; if (bus.count !== 14'd9998) begin errs++; $display("FAIL sat final count: got %0d want 9998", bus.count); end
  endtask

  task automatic test_presets();
    apply(4'h0, 1'b0, 1'b1, 1'b0);
    apply(4'b1000, 1'b0, 1'b0, 1'b0);
    apply(4'b0001, 1'b0, 1'b0, 1'b0);
    repeat (10) apply(4'h0, 1'b0, 1'b0, 1'b1);
    idle(3);
    vecs++; if (bus.count !== 14'd500) begin errs++; $display("FAIL preset preload count: got %0d want 500", bus.count); end
    apply(4'h0, 1'b1, 1'b1, 1'b0);
    idle(1);
    vecs++; if (bus.grant !== 7'h20) begin errs++; $display("FAIL preset first grant: got %b want 0100000", bus.grant); end
    vecs++; if (bus.count !== 14'd150) begin errs++; $display("FAIL preset first count: got %0d want 150", bus.count); end
    idle(1);
    vecs++; if (bus.grant !== 7'h10) begin errs++; $display("FAIL preset second grant: got %b want 0010000", bus.grant); end
    vecs++; if (bus.count !== 14'd15) begin errs++; $display("FAIL preset second count: got %0d want 15", bus.count); end
  endtask

  task automatic test_pend_overflow();
    repeat (3) apply(4'b0010, 1'b0, 1'b1, 1'b0);
    vecs++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL ovf early: got %b want 0", bus.ovf); end
    apply(4'b0010, 1'b0, 1'b1, 1'b0);
    vecs++; if (bus.ovf !== 1'b1 || m_ovf != 1) begin errs++; $display("FAIL ovf set: got %b want 1", bus.ovf); end
    idle(5);
    vecs++; if (bus.count !== 14'd510 || m_count != 510) begin errs++; $display("FAIL ovf count: got %0d want 510", bus.count); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL ovf drained busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_burst();
    apply(4'hF, 1'b0, 1'b0, 1'b1);
    apply(4'hF, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    vecs++; if (bus.count !== 14'd0) begin errs++; $display("FAIL midrst count: got %0d want 0", bus.count); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
    vecs++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL midrst ovf: got %b want 0", bus.ovf); end
    vecs++; if (bus.grant !== 7'd0) begin errs++; $display("FAIL midrst grant: got %b want 0", bus.grant); end
    model_reset();
    apply(4'hF, 1'b1, 1'b1, 1'b1);
    apply(4'hF, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      vecs++; if (bus.grant !== 7'd0 || bus.busy !== 1'b0) begin errs++; $display("FAIL midrst release cycle %0d: grant %b busy %b want 0 0", i, bus.grant, bus.busy); end
    end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic r1, r2, tk;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) a[b] = ($urandom_range(0, 99) < 20);
      r1 = ($urandom_range(0, 99) < 5);
      r2 = ($urandom_range(0, 99) < 3);
      tk = ($urandom_range(0, 99) < 40);
      apply(a, r1, r2, tk);
      vecs++;
      if (bus.count !== 14'(m_count) || bus.grant !== 7'(m_grant) || bus.expired !== 1'(m_exp)
          || bus.ovf !== 1'(m_ovf) || bus.busy !== 1'(model_busy())) begin
        errs++;
        $display("FAIL random cycle %0d: got cnt=%0d gnt=%b exp=%b ovf=%b busy=%b want cnt=%0d gnt=%b exp=%0d ovf=%0d busy=%0d",
                 c, bus.count, bus.grant, bus.expired, bus.ovf, bus.busy, m_count, 7'(m_grant), m_exp, m_ovf, model_busy());
      end
    end
  endtask

  initial begin
    bus.add_req = '0; bus.rst1_req = 1'b0; bus.rst2_req = 1'b0; bus.tick = 1'b0;
    model_reset();
    test_reset();
    test_tick_at_zero();
    test_add_single();
    test_add_all_saturate();
    test_presets();
    test_pend_overflow();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/meter_update_arbiter.md
# meter_update_arbiter

Arbitration and sequencing controller for the parking meter's shared time register. It collects one-cycle request strobes from the four add sources, the two preset sources and the 1 s tick divider. It grants exactly one update per clock and applies it to the 14-bit remaining-time count with saturation. Its output feeds the BCD conversion and display stages, so no two events ever race on the counter.

## Interface
Parameters:
- MAX_COUNT, 9999: saturation ceiling.
- ADD_VAL0..ADD_VAL3, 60/120/180/300: seconds added per add source 0..3.
- RST1_VAL, 15: preset value for request 1.
- RST2_VAL, 150: preset value for request 2.
- PEND_MAX, 3: saturation limit of each per-source pending counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low (asserted at 0).
- add_req  input  4  one-cycle add strobes; bit i selects ADD_VALi.
- rst1_req  input  1  one-cycle strobe: preset count to RST1_VAL.
- rst2_req  input  1  one-cycle strobe: preset count to RST2_VAL.
- tick  input  1  one-cycle 1 s strobe: decrement count.
- count  output  14  remaining time, 0..MAX_COUNT.
- grant  output  7  one-hot, valid for one cycle. Bits [3:0] add, [4] rst1, [5] rst2, [6] tick.
- expired  output  1  one-cycle pulse when a tick takes count from 1 to 0.
- ovf  output  1  sticky: a request was lost to pending saturation.
- busy  output  1  high while any request is pending.

## Operation
- Requests are captured into pending counters.
  - Each add source and the tick source has a 2-bit counter saturating at PEND_MAX.
  - rst1 and rst2 each have a 1-bit flag.
  - A strobe that arrives while its counter is at PEND_MAX is dropped and sets ovf.
- One grant per cycle, chosen from pending state only, with fixed priority: rst2 > rst1 > add group > tick.
- The add group uses 4-way round-robin. The pointer moves to the slot after the last granted add and only moves on an add grant.
- Rst1 and rst2 both pending: rst2 is granted first, and rst1 follows on the next cycle (both are applied in order).
- The granted source's pending counter decrements; a flag clears.
  - If a new strobe from the same source arrives on the grant cycle, the counter is unchanged (net +1 −1).
- Counter update on each grant:
  - add i: count = min(count + ADD_VALi, MAX_COUNT). Compute in 15 bits, then clamp.
  - rst1 / rst2: count = RST1_VAL / RST2_VAL.
  - tick: count = count − 1 if count > 0. At 0 the tick is consumed, count stays 0 and expired does not pulse.
- expired pulses only when a tick grant moves count from 1 to 0.
- busy = OR of all pending counters and flags.
- Reset (rst=0, any time including mid-arbitration):
  - count = 0, grant = 0, expired = 0, ovf = 0, busy = 0.
  - All pending state cleared, round-robin pointer = source 0.
  - Requests sampled while in reset are discarded.

## Timing
- A strobe high in cycle k is captured at the edge ending cycle k.
- The earliest grant is decided at the next edge (end of cycle k+1).
  - grant and the updated count are visible in cycle k+2. Minimum latency: 2 edges.
- grant, count and expired are registered and change on the same edge.
- Worst case, a tick waits behind at most 2 preset grants plus 4×PEND_MAX add grants, i.e. 14 cycles.
- The tick source is never starved beyond that bound provided strobes are not continuous.
- No handshake back to requesters: requesters treat strobes as fire-and-forget. ovf is the only loss indication.

## Structure
- Shared package parking_pkg holds:
  - MAX_COUNT, the ADD_VAL and RST_VAL constants.
  - Grant-bit index constants (GNT_ADD0..GNT_TICK).
  - The 14-bit count width.
- One sub-module, rr_arbiter4: 4-bit request in, one-hot grant out, and an advance enable that updates the internal pointer.
- The priority mux, pending counters and saturating adder live in the top module.

## Test plan
- Reset, then tick ×3 -> count stays 0, grant[6] pulses each time, expired never pulses, ovf = 0.
- add_req = 4'b0001, then wait -> grant[0] pulses 2 edges after the strobe; count = 60. Three ticks -> count = 57.
- add_req = 4'b1111 and tick in the same cycle, count = 9800 -> grants in order add0, add1, add2, add3, tick. Count saturates at 9999 after add2 (9800 + 60 + 120 + 180 clamps); the tick then gives 9998.
- rst1_req and rst2_req in the same cycle, count = 500 -> rst2 is granted first (count = 150), then rst1 (count = 15).
- Four add_req[1] strobes on consecutive cycles while rst2 is held pending -> ovf = 1. Three add1 grants follow: count = min(RST2_VAL + 360, 9999) = 510.
- rst driven low mid-burst with pending adds and count = 1234 -> count = 0, busy = 0 immediately. No grant after release until a new strobe arrives.
